vga_text_fb: RTL

VGA_TEXT_FB -- requirements
Module: vga_text_fb

---
 rtl/vga_text_fb_pkg.sv | 42 ++++
 rtl/vga_font_rom.sv | 57 +++++
 rtl/vga_text_fb.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_fb_pkg.sv
//------------------------------------------------------------------------------
// Module   : vga_text_fb_pkg
// Purpose  : Shared geometry, bus command codes, FSM state and colour constants.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vga_text_fb_pkg;

    localparam int unsigned H_ACTIVE = 1280;
    localparam int unsigned V_ACTIVE = 1024;
    localparam int unsigned CELL_W   = 8;
    localparam int unsigned CELL_H   = 16;
    localparam int unsigned CELLS    = 10240;

    localparam logic [13:0] ADDR_CLEAR  = 14'h3FFE;
    localparam logic [13:0] ADDR_CURSOR = 14'h3FFF;

    localparam logic [7:0] RGB_BLACK  = 8'h00;
    localparam logic [7:0] RGB_WHITE  = 8'hFF;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_e;

    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] data;
    } bus_wr_t;

    // Row-major cell index with 160 columns, built from shifts: r*128 + r*32 + c.
    function automatic logic [13:0] cell_index(input logic [5:0] r, input logic [7:0] c);
        logic [13:0] r14;
        r14 = {8'd0, r};
        return (r14 << 7) + (r14 << 5) + {6'd0, c};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_font_rom.sv
//------------------------------------------------------------------------------
// Module   : vga_font_rom
// Purpose  : 256 x 16 row 8x16 glyph ROM, combinational, MSB is leftmost pixel.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_font_rom (
    input  logic [11:0] i_addr,
    output logic [7:0]  o_data
);

    logic [7:0] w_code;
    logic [3:0] w_row;

    assign w_code = i_addr[11:4];
    assign w_row  = i_addr[3:0];

    always_comb begin
        o_data = 8'h00;
        case (w_code)
            8'h00, 8'h20: o_data = 8'h00;
            8'h41: begin
                case (w_row)
                    4'd2:                      o_data = 8'h10;
                    4'd3:                      o_data = 8'h38;
                    4'd4:                      o_data = 8'h6C;
                    4'd5, 4'd6:                o_data = 8'hC6;
                    4'd7:                      o_data = 8'hFE;
                    4'd8, 4'd9, 4'd10, 4'd11:  o_data = 8'hC6;
                    default:                   o_data = 8'h00;
                endcase
            end
            8'h42: begin
                case (w_row)
                    4'd2, 4'd11:               o_data = 8'hFC;
                    4'd6:                      o_data = 8'h7C;
                    4'd3, 4'd4, 4'd5,
                    4'd7, 4'd8, 4'd9, 4'd10:   o_data = 8'h66;
                    default:                   o_data = 8'h00;
                endcase
            end
            8'hDB: o_data = 8'hFF;
            default: begin
                // Codes without a drawn glyph render as a hollow box.
                case (w_row)
                    4'd2, 4'd13:               o_data = 8'h7E;
                    4'd0, 4'd1, 4'd14, 4'd15:  o_data = 8'h00;
                    default:                   o_data = 8'h42;
                endcase
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/vga_text_fb.sv
//------------------------------------------------------------------------------
// Module   : vga_text_fb
// Purpose  : 160x64 text frame buffer with bus write queue, clear engine and
//            blinking underline cursor; pixel output is combinational.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_text_fb
    import vga_text_fb_pkg::*;
#(
    parameter int COLS       = 160,
    parameter int ROWS       = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [20:0] pix_addr,
    output logic [7:0]  data_out,
    input  logic        bus_we,
    input  logic [13:0] bus_addr,
    input  logic [15:0] bus_wdata,
    output logic        bus_ready,
    output logic        busy
);

    localparam int          c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int          c_CX    = $clog2(CELL_W);
    localparam int          c_CY    = $clog2(CELL_H);
    localparam logic [13:0] c_CELLS = 14'(COLS * ROWS);
    localparam logic [13:0] c_LAST  = 14'(COLS * ROWS - 1);

    fb_state_e            state_q,     state_d;
    logic [c_PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [c_CNT_W-1:0]   count_q,     count_d;
    logic [13:0]          cursor_q,    cursor_d;
    logic [4:0]           frame_cnt_q, frame_cnt_d;
    logic [20:0]          prev_pix_q,  prev_pix_d;
    logic [13:0]          clr_idx_q,   clr_idx_d;
    logic [7:0]           fill_q,      fill_d;

    bus_wr_t              fifo_mem [FIFO_DEPTH];
    logic [15:0]          char_ram [COLS*ROWS];

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    bus_wr_t              w_head;
    logic                 w_ram_we;
    logic [13:0]          w_ram_waddr;
    logic [15:0]          w_ram_wdata;

    logic [10:0]          w_col;
    logic [9:0]           w_row;
    logic [7:0]           w_cell_col;
    logic [5:0]           w_cell_row;
    logic [3:0]           w_glyph_row;
    logic [2:0]           w_glyph_px;
    logic                 w_active;
    logic [13:0]          w_rd_idx;
    logic [15:0]          w_cell;
    logic [7:0]           w_font_bits;
    logic                 w_cursor_hit;
    logic                 w_frame_tick;

    // ---------------- Bus write queue ----------------
    assign w_full    = (count_q == c_CNT_W'(FIFO_DEPTH));
    assign bus_ready = !w_full;
    assign w_push    = bus_we && !w_full;
    assign w_head    = fifo_mem[rd_ptr_q];
    assign busy      = (state_q == ST_CLEAR) || (count_q != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= '{addr: bus_addr, data: bus_wdata};
        end
    end

    // ---------------- Control FSM and next-state logic ----------------
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        fill_d      = fill_q;
        cursor_d    = cursor_q;
        w_pop       = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_waddr = clr_idx_q;
        w_ram_wdata = {fill_q, CHAR_SPACE};

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    w_pop = 1'b1;
                    if (w_head.addr == ADDR_CURSOR) begin
                        cursor_d = w_head.data[13:0];
                    end else if (w_head.addr == ADDR_CLEAR) begin
                        state_d   = ST_CLEAR;
                        clr_idx_d = '0;
                        fill_d    = w_head.data[15:8];
                    end else if (w_head.addr < c_CELLS) begin
                        w_ram_we    = 1'b1;
                        w_ram_waddr = w_head.addr;
                        w_ram_wdata = w_head.data;
                    end
                end
            end
            ST_CLEAR: begin
                w_ram_we = 1'b1;
                if (clr_idx_q == c_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + 14'd1;
                end
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Frame start is detected as the scan address returning to zero.
    assign w_frame_tick = (pix_addr == 21'd0) && (prev_pix_q != 21'd0);

    always_comb begin
        prev_pix_d  = pix_addr;
        frame_cnt_d = frame_cnt_q + {4'd0, w_frame_tick};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cursor_q    <= ADDR_CURSOR;
            frame_cnt_q <= '0;
            prev_pix_q  <= '0;
            clr_idx_q   <= '0;
            fill_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cursor_q    <= cursor_d;
            frame_cnt_q <= frame_cnt_d;
            prev_pix_q  <= prev_pix_d;
            clr_idx_q   <= clr_idx_d;
            fill_q      <= fill_d;
        end
    end

    // Character RAM is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            char_ram[w_ram_waddr] <= w_ram_wdata;
        end
    end

    // ---------------- Pixel path ----------------
    assign w_col       = pix_addr[10:0];
    assign w_row       = pix_addr[20:11];
    assign w_cell_col  = w_col[10:c_CX];
    assign w_cell_row  = w_row[9:c_CY];
    assign w_glyph_row = w_row[c_CY-1:0];
    assign w_glyph_px  = w_col[c_CX-1:0];
    assign w_active    = (w_col < 11'(H_ACTIVE)) && ({1'b0, w_row} < 11'(V_ACTIVE));
    // Off-screen addresses are steered to cell 0 so the read never leaves the array.
    assign w_rd_idx    = w_active ? cell_index(w_cell_row, w_cell_col) : 14'd0;
    assign w_cell      = char_ram[w_rd_idx];

    vga_font_rom u_font (
        .i_addr (w_cell[7:0] & 8'hFF ? {w_cell[7:0], w_glyph_row} : {8'h00, w_glyph_row}),
        .o_data (w_font_bits)
    );

    assign w_cursor_hit = (cursor_q < c_CELLS) && (w_rd_idx == cursor_q)
                          && !frame_cnt_q[4] && (w_glyph_row >= 4'd14);

    always_comb begin
        data_out = RGB_BLACK;
        if (rst || !w_active) begin
            data_out = RGB_BLACK;
        end else if (w_cursor_hit) begin
            data_out = RGB_WHITE;
        end else if (w_font_bits[3'd7 - w_glyph_px]) begin
            data_out = w_cell[15:8];
        end
    end

endmodule

`default_nettype wire
